seq_det_ctrl: RTL and testbench

Programmable serial pattern-detector controller. It accepts a pattern configuration through a valid/ready handshake, then scans a qualified serial bit stream for that pattern. It counts matches and stops on a programmable match target. It generalises the team's fixed-pattern detectors, such as the "1110" detector, into one configurable, software-sequenced block.

---
 rtl/seq_det_ctrl_if.sv | 36 +++
 rtl/seq_det_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Configuration channel for seq_det_ctrl: pattern, length, overlap mode and target.
// Latency: none, wires only.
// Backpressure: cfg_ready is driven by the controller; a transfer happens when cfg_valid && cfg_ready.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;

  // Software/sequencer side offers the configuration.
  modport master (
    output cfg_valid,
    output cfg_pattern,
    output cfg_len,
    output cfg_overlap,
    output cfg_target,
    input  cfg_ready
  );

  // Controller side accepts it.
  modport slave (
    input  cfg_valid,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_overlap,
    input  cfg_target,
    output cfg_ready
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with match counter and target stop.
// Latency: sample taken at edge N gives match (and done, if the target is hit) in cycle N+1.
// Backpressure: cfg_ready only in IDLE; serial input has no backpressure, x_valid qualifies each bit.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    cfg,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;

  // Latched configuration.
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;

  // Serial history, newest bit in [0], and how many of its bits are usable.
  logic [PAT_W-1:0] history;
  logic [LEN_W-1:0] bits_seen;

  // Combinational helpers.
  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] new_hist;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] bits_next;
  logic [LEN_W:0]   seen_plus;
  logic [CNT_W-1:0] count_inc;
  logic             hit;
  logic             tgt_reached;

  // Configuration is only accepted in IDLE.
  assign cfg.cfg_ready = (state == IDLE);

  // Length 0 or beyond the pattern register means "use the full width".
  always_comb begin
    len_clamped = cfg.cfg_len;
    if (cfg.cfg_len == '0 || cfg.cfg_len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  // Hit detection on the history as it will look after shifting in x.
  always_comb begin
    new_hist = {history[PAT_W-2:0], x};
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    // One extra bit so bits_seen+1 cannot wrap when PAT_W+1 is a power of two.
    seen_plus   = {1'b0, bits_seen} + (LEN_W+1)'(1);
    bits_next   = (bits_seen == LEN_W'(PAT_W)) ? bits_seen : bits_seen + LEN_W'(1);
    hit         = (seen_plus >= {1'b0, len_q}) &&
                  (((new_hist ^ pat_q) & len_mask) == '0);
    count_inc   = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    tgt_reached = (tgt_q != '0) && (count_inc == tgt_q);
  end

  // Controller FSM with all outputs registered; stop beats start beats cfg beats data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      history     <= '0;
      bits_seen   <= '0;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (!stop && cfg.cfg_valid) begin
            pat_q <= cfg.cfg_pattern;
            len_q <= len_clamped;
            ovl_q <= cfg.cfg_overlap;
            tgt_q <= cfg.cfg_target;
            state <= ARMED;
          end
        end

        ARMED: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            history     <= '0;
            bits_seen   <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            // Any sample in this cycle is dropped.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            // Restart; the sample in this cycle is dropped.
            history     <= '0;
            bits_seen   <= '0;
            match_count <= '0;
          end else if (x_valid) begin
            history <= new_hist;
            if (hit) begin
              match       <= 1'b1;
              match_count <= count_inc;
              // Without overlap, bits already consumed by this match are retired.
              bits_seen   <= ovl_q ? bits_next : '0;
              if (tgt_reached) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              bits_seen <= bits_next;
            end
          end
        end

        DONE: begin
          if (stop) begin
            done  <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            history     <= '0;
            bits_seen   <= '0;
            match_count <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // busy and done describe different states and never overlap.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst) !(busy && done));

  // A match pulse always leaves a nonzero count behind it.
  a_match_count: assert property (@(posedge clk) disable iff (!rst) match |-> (match_count != '0));

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed vectors plus a queue-based reference model.
// Latency: model updates at each rising edge, compared on each falling edge.
// Backpressure: configuration is only offered while the controller is idle.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, x = 1'b0, x_valid = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) cif ();

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cif),
    .start       (start),
    .stop        (stop),
    .x           (x),
    .x_valid     (x_valid),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_st  = S_IDLE;
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  bit         m_ovl = 1'b0;
  int         m_tgt = 0;
  int         m_cnt = 0;
  bit         m_match = 1'b0;
  bit         q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit();
    if (q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_clear();
    q.delete();
    m_cnt = 0;
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_tgt = 0;
    m_cnt = 0; m_match = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    m_match = 1'b0;
    case (m_st)
      S_IDLE: if (!stop && cif.cfg_valid) begin
        m_pat = cif.cfg_pattern;
        m_len = int'(cif.cfg_len);
        if (m_len == 0 || m_len > PAT_W) m_len = PAT_W;
        m_ovl = cif.cfg_overlap;
        m_tgt = int'(cif.cfg_target);
        m_st  = S_ARMED;
      end
      S_ARMED: if (stop) m_st = S_IDLE;
               else if (start) begin m_clear(); m_st = S_RUN; end
      S_RUN: if (stop) m_st = S_IDLE;
             else if (start) m_clear();
             else if (x_valid) begin
               q.push_back(x);
               if (q.size() > PAT_W) void'(q.pop_front());
               if (m_hit()) begin
                 m_match = 1'b1;
                 if (m_cnt < CNT_MAX) m_cnt++;
                 if (!m_ovl) q.delete();
                 if (m_tgt != 0 && m_cnt == m_tgt) m_st = S_DONE;
               end
             end
      S_DONE: if (stop) m_st = S_IDLE;
              else if (start) begin m_clear(); m_st = S_RUN; end
      default: m_st = S_IDLE;
    endcase
  endtask

  // Model follows the same clock and asynchronous reset as the DUT.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_match", 32'(match), 32'(m_match));
    chk("cyc_count", 32'(match_count), 32'(m_cnt));
    chk("cyc_busy", 32'(busy), 32'(m_st == S_RUN));
    chk("cyc_done", 32'(done), 32'(m_st == S_DONE));
    chk("cyc_cfg_ready", 32'(cif.cfg_ready), 32'(m_st == S_IDLE));
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input bit ovl, input logic [7:0] tgt);
    chk("cfg_ready_idle", 32'(cif.cfg_ready), 32'd1);
    cif.cfg_valid   = 1'b1;
    cif.cfg_pattern = pat;
    cif.cfg_len     = len;
    cif.cfg_overlap = ovl;
    cif.cfg_target  = tgt;
    tick();
    cif.cfg_valid = 1'b0;
    chk("cfg_ready_armed", 32'(cif.cfg_ready), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Sends n bits, MSB of the low n first; exp gives the match pulse expected after each bit.
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp,
                        input string nm);
    for (int i = n - 1; i >= 0; i--) begin
      x = bits[i]; x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      chk(nm, 32'(match), 32'(exp[i]));
    end
  endtask

  task automatic gap(input bit v);
    x = v; x_valid = 1'b0; tick();
    chk("gap_no_match", 32'(match), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    cif.cfg_valid = 1'b0; cif.cfg_pattern = '0; cif.cfg_len = '0;
    cif.cfg_overlap = 1'b0; cif.cfg_target = '0;
    tick(); tick();
    chk("rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();

    // 1: 1110, no overlap, free running.
    do_cfg(8'h0E, 4'd4, 1'b0, 8'd0);
    do_start();
    chk("t1_busy_start", 32'(busy), 32'd1);
    stream(16'b111101110, 9, 16'b000010001, "t1_match");
    chk("t1_count", 32'(match_count), 32'd2);
    chk("t1_done", 32'(done), 32'd0);
    do_stop();

    // 2: 101 with and without overlap.
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    stream(16'b10101, 5, 16'b00101, "t2o_match");
    chk("t2o_count", 32'(match_count), 32'd2);
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    do_start();
    stream(16'b10101, 5, 16'b00100, "t2n_match");
    chk("t2n_count", 32'(match_count), 32'd1);
    do_stop();
    chk("t2_count_after_stop", 32'(match_count), 32'd1);

    // 3: target 2 ends the run; further patterns ignored.
    do_cfg(8'b110, 4'd3, 1'b0, 8'd2);
    do_start();
    stream(16'b110110, 6, 16'b001001, "t3_match");
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    stream(16'b110, 3, 16'b000, "t3_ignored");
    chk("t3_count_hold", 32'(match_count), 32'd2);
    do_start();
    chk("t3_restart_count", 32'(match_count), 32'd0);
    chk("t3_restart_busy", 32'(busy), 32'd1);

    // 4: 110 with gaps where x toggles unqualified.
    stream(16'b1, 1, 16'b0, "t4_match");
    gap(1'b0); gap(1'b1);
    stream(16'b1, 1, 16'b0, "t4_match");
    gap(1'b0); gap(1'b1); gap(1'b0);
    stream(16'b0, 1, 16'b1, "t4_match");
    chk("t4_count", 32'(match_count), 32'd1);

    // 5: stop together with a completing sample.
    stream(16'b11, 2, 16'b00, "t5_match");
    x = 1'b0; x_valid = 1'b1; stop = 1'b1;
    tick();
    x_valid = 1'b0; stop = 1'b0;
    chk("t5_no_match", 32'(match), 32'd0);
    chk("t5_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count_hold", 32'(match_count), 32'd1);

    // 6: asynchronous reset mid-run, while match is high.
    do_cfg(8'h0E, 4'd4, 1'b1, 8'd0);
    do_start();
    stream(16'b1110, 4, 16'b0001, "t6_match");
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_match", 32'(match), 32'd0);
    chk("t6_rst_count", 32'(match_count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    do_start();
    chk("t6_start_ignored_busy", 32'(busy), 32'd0);
    chk("t6_start_ignored_ready", 32'(cif.cfg_ready), 32'd1);

    // Length 0 clamps to the full 8-bit pattern.
    do_cfg(8'hA5, 4'd0, 1'b0, 8'd0);
    do_start();
    chk("t7_busy", 32'(busy), 32'd1);
    stream(16'b0110100101, 10, 16'b0000000001, "t7_match");
    chk("t7_count", 32'(match_count), 32'd1);
    do_stop();

    // Length above PAT_W also clamps to 8.
    do_cfg(8'hC3, 4'd12, 1'b0, 8'd1);
    do_start();
    stream(16'b11000011, 8, 16'b00000001, "t8_match");
    chk("t8_done", 32'(done), 32'd1);
    do_stop();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
